rf_arbiter: RTL and testbench

RF_ARBITER -- requirements
Module: rf_arbiter

---
 rtl/rf_arb_pkg.sv | 23 ++
 rtl/rf_arb_fsm.sv | 119 +++++++++++
 rtl/rf_arbiter.sv | 118 +++++++++++
 tb/tb_rf_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared types and default widths for the two-port register
//               file arbiter (state encoding, data/address width defaults).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned ADDR_W_DEF    = 3;
    localparam int unsigned MAX_BURST_DEF = 4;

    // Arbitration state: free-for-all, or one port holding a lock.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage : rf_arb_pkg
`default_nettype wire

// File: rtl/rf_arb_fsm.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_fsm
// Description : Arbitration core. Holds the lock state, round-robin pointer
//               and burst counter; produces combinational one-hot grants.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               req0_i / req1_i       - pending access requests
//               lock0_i / lock1_i     - request to keep ownership
//               gnt0_o / gnt1_o       - access granted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rf_arb_fsm
    import rf_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic lock0_i,
    input  logic lock1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    arb_state_e       r_state_q, w_state_d;
    logic             r_ptr_q,   w_ptr_d;   // 0: port 0 wins a tie in IDLE
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic             w_gnt0, w_gnt1;

    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_cnt_d   = r_cnt_q;
        if (!reset) begin
            case (r_state_q)
                IDLE: begin
                    if (req0_i && (!req1_i || !r_ptr_q)) begin
                        w_gnt0  = 1'b1;
                        w_ptr_d = 1'b1;
                        if (lock0_i) begin
                            w_state_d = OWN0;
                            w_cnt_d   = c_ONE;
                        end
                    end else if (req1_i) begin
                        w_gnt1  = 1'b1;
                        w_ptr_d = 1'b0;
                        if (lock1_i) begin
                            w_state_d = OWN1;
                            w_cnt_d   = c_ONE;
                        end
                    end
                end
                OWN0: begin
                    // Owner keeps the port until its burst is spent, but only
                    // yields once the other port is actually waiting.
                    if (req0_i && ((r_cnt_q < c_MAX) || !req1_i)) begin
                        w_gnt0 = 1'b1;
                        if (!lock0_i) begin
                            w_state_d = IDLE;
                            w_cnt_d   = '0;
                        end else if (r_cnt_q < c_MAX) begin
                            w_cnt_d = r_cnt_q + c_ONE;
                        end
                    end else if (req1_i) begin
                        w_gnt1    = 1'b1;
                        w_state_d = IDLE;
                        w_cnt_d   = '0;
                        w_ptr_d   = 1'b0;
                    end
                end
                OWN1: begin
                    if (req1_i && ((r_cnt_q < c_MAX) || !req0_i)) begin
                        w_gnt1 = 1'b1;
                        if (!lock1_i) begin
                            w_state_d = IDLE;
                            w_cnt_d   = '0;
                        end else if (r_cnt_q < c_MAX) begin
                            w_cnt_d = r_cnt_q + c_ONE;
                        end
                    end else if (req0_i) begin
                        w_gnt0    = 1'b1;
                        w_state_d = IDLE;
                        w_cnt_d   = '0;
                        w_ptr_d   = 1'b1;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_ptr_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign gnt0_o = w_gnt0;
    assign gnt1_o = w_gnt1;

endmodule : rf_arb_fsm
`default_nettype wire

// File: rtl/rf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_arbiter
// Description : Two-port arbiter in front of a single-write/single-read
//               register file. One access per cycle; reads return registered
//               data with one cycle of latency.
// Ports       : clk, reset                - clock, synchronous active-high reset
//               req/we/addr/wdata/lock 0/1 - per-port access request
//               gnt0/gnt1                 - access performed this cycle
//               rvalid0/1, rdata0/1       - read response (1-cycle pulse)
//               rf_we/rf_wAddr/rf_wData   - register file write port
//               rf_rAddr/rf_rData         - register file read port
// Revision    : 1.0 - initial release
// ============================================================================
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wAddr,
    output logic [DATA_W-1:0] rf_wData,
    output logic [ADDR_W-1:0] rf_rAddr,
    input  logic [DATA_W-1:0] rf_rData
);

    logic              w_gnt0, w_gnt1;
    logic              w_rd0, w_rd1, w_wr0, w_wr1;
    logic              r_rvalid0_q, r_rvalid1_q;
    logic [DATA_W-1:0] r_rdata0_q, r_rdata1_q;

    rf_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .req0_i  (req0),
        .req1_i  (req1),
        .lock0_i (lock0),
        .lock1_i (lock1),
        .gnt0_o  (w_gnt0),
        .gnt1_o  (w_gnt1)
    );

    assign w_wr0 = w_gnt0 &  we0;
    assign w_rd0 = w_gnt0 & ~we0;
    assign w_wr1 = w_gnt1 &  we1;
    assign w_rd1 = w_gnt1 & ~we1;

    // Unused register file fields are forced to zero so the bus is quiet
    // whenever nothing is being accessed.
    always_comb begin
        rf_we    = w_wr0 | w_wr1;
        rf_wAddr = '0;
        rf_wData = '0;
        rf_rAddr = '0;
        if (w_wr0) begin
            rf_wAddr = addr0;
            rf_wData = wdata0;
        end else if (w_wr1) begin
            rf_wAddr = addr1;
            rf_wData = wdata1;
        end
        if (w_rd0) begin
            rf_rAddr = addr0;
        end else if (w_rd1) begin
            rf_rAddr = addr1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid0_q <= 1'b0;
            r_rvalid1_q <= 1'b0;
            r_rdata0_q  <= '0;
            r_rdata1_q  <= '0;
        end else begin
            r_rvalid0_q <= w_rd0;
            r_rvalid1_q <= w_rd1;
            if (w_rd0) begin
                r_rdata0_q <= rf_rData;
            end
            if (w_rd1) begin
                r_rdata1_q <= rf_rData;
            end
        end
    end

    // A reset arriving right after a read swallows the pending valid pulse.
    assign rvalid0 = r_rvalid0_q & ~reset;
    assign rvalid1 = r_rvalid1_q & ~reset;
    assign rdata0  = r_rdata0_q;
    assign rdata1  = r_rdata1_q;
    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;

endmodule : rf_arbiter
`default_nettype wire

// File: tb/tb_rf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_arbiter
// Description : Directed self-checking bench for rf_arbiter with a behavioural
//               8x32 register file attached to its rf_* ports.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic        lock0 = 1'b0, lock1 = 1'b0;
    logic [2:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, rf_we;
    logic [31:0] rdata0, rdata1, rf_wData, rf_rData;
    logic [2:0]  rf_wAddr, rf_rAddr;
    logic [31:0] mem [0:7];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_arbiter #(
        .DATA_W    (32),
        .ADDR_W    (3),
        .MAX_BURST (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .lock0    (lock0),
        .lock1    (lock1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rf_we    (rf_we),
        .rf_wAddr (rf_wAddr),
        .rf_wData (rf_wData),
        .rf_rAddr (rf_rAddr),
        .rf_rData (rf_rData)
    );

    // Register file model
    always @(posedge clk) begin
        if (rf_we) mem[rf_wAddr] <= rf_wData;
    end
    assign rf_rData = mem[rf_rAddr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, settle, then return.
    task automatic drv(input logic rst,
                       input logic r0, input logic w0, input logic l0,
                       input logic [2:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [2:0] a1, input logic [31:0] d1);
        @(negedge clk);
        reset = rst;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        #1;
    endtask

    initial begin
        // Reset held with a request pending: nothing may be granted
        drv(1, 1,1,0,3'd3,32'hDEADBEEF, 0,0,0,3'd0,32'h0);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_wAddr, 0);
        chk("rst_wdata", rf_wData, 0);

        drv(0, 0,0,0,3'd0,32'h0, 0,0,0,3'd0,32'h0);
        chk("post_rst_rvalid0", rvalid0, 0);
        chk("post_rst_rvalid1", rvalid1, 0);
        chk("post_rst_rdata0", rdata0, 0);
        chk("post_rst_rdata1", rdata1, 0);

        // Write then read back through port 0
        drv(0, 1,1,0,3'd3,32'hDEADBEEF, 0,0,0,3'd0,32'h0);
        chk("wr_gnt0", gnt0, 1);
        chk("wr_gnt1", gnt1, 0);
        chk("wr_we", rf_we, 1);
        chk("wr_waddr", rf_wAddr, 3);
        chk("wr_wdata", rf_wData, 32'hDEADBEEF);
        chk("wr_raddr", rf_rAddr, 0);
        drv(0, 1,0,0,3'd3,32'h0, 0,0,0,3'd0,32'h0);
        chk("rd_gnt0", gnt0, 1);
        chk("rd_we", rf_we, 0);
        chk("rd_raddr", rf_rAddr, 3);
        chk("rd_waddr", rf_wAddr, 0);
        drv(0, 0,0,0,3'd0,32'h0, 0,0,0,3'd0,32'h0);
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata0", rdata0, 32'hDEADBEEF);
        chk("rd_idle_gnt0", gnt0, 0);
        chk("rd_rvalid1", rvalid1, 0);

        // Re-reset so the round-robin pointer starts at port 0
        drv(1, 0,0,0,3'd0,32'h0, 0,0,0,3'd0,32'h0);
        chk("rst2_rvalid0", rvalid0, 0);

        // Both reading without lock: alternating 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            drv(0, 1,0,0,3'd3,32'h0, 1,0,0,3'd3,32'h0);
            chk("rr_gnt0", gnt0, (i % 2) == 0);
            chk("rr_gnt1", gnt1, (i % 2) == 1);
            if (i == 2) begin
                chk("rr_rvalid1", rvalid1, 1);
                chk("rr_rdata1", rdata1, 32'hDEADBEEF);
            end
        end

        // Single grant to port 0 leaves the pointer at port 1
        drv(0, 1,0,0,3'd3,32'h0, 0,0,0,3'd0,32'h0);
        chk("ptr_gnt0", gnt0, 1);

        // Port 1 locks: four bursts, one handoff to port 0, then port 1 again
        for (int i = 0; i < 6; i++) begin
            drv(0, 1,0,0,3'd3,32'h0, 1,1,1,3'd5,32'hCAFE0001);
            chk("burst1_gnt1", gnt1, i != 4);
            chk("burst1_gnt0", gnt0, i == 4);
            if (i == 0) begin
                chk("burst1_waddr", rf_wAddr, 5);
                chk("burst1_wdata", rf_wData, 32'hCAFE0001);
            end
            if (i == 4) begin
                chk("burst1_handoff_we", rf_we, 0);
                chk("burst1_handoff_raddr", rf_rAddr, 3);
            end
        end

        // Owner stops requesting: waiting port is served
        drv(0, 1,0,0,3'd3,32'h0, 0,0,0,3'd0,32'h0);
        chk("own1_release_gnt0", gnt0, 1);
        chk("own1_release_gnt1", gnt1, 0);

        // Port 0 locked alone for six cycles: never interrupted
        for (int i = 0; i < 6; i++) begin
            drv(0, 1,0,1,3'd5,32'h0, 0,0,0,3'd0,32'h0);
            chk("solo0_gnt0", gnt0, 1);
            chk("solo0_gnt1", gnt1, 0);
            if (i == 1) begin
                chk("solo0_rvalid0", rvalid0, 1);
                chk("solo0_rdata0", rdata0, 32'hCAFE0001);
            end
        end
        // Counter saturated at the limit: a new requester wins immediately
        drv(0, 1,0,1,3'd5,32'h0, 1,0,0,3'd3,32'h0);
        chk("sat_gnt1", gnt1, 1);
        chk("sat_gnt0", gnt0, 0);

        // Reset right after a locked read
        drv(0, 1,0,1,3'd3,32'h0, 0,0,0,3'd0,32'h0);
        chk("own0_rd1_gnt0", gnt0, 1);
        drv(0, 1,0,1,3'd3,32'h0, 0,0,0,3'd0,32'h0);
        chk("own0_rd2_gnt0", gnt0, 1);
        drv(1, 0,0,0,3'd0,32'h0, 0,0,0,3'd0,32'h0);
        chk("abort_rvalid0_in_rst", rvalid0, 0);
        chk("abort_gnt0_in_rst", gnt0, 0);
        drv(0, 1,0,0,3'd3,32'h0, 1,0,0,3'd3,32'h0);
        chk("abort_rvalid0", rvalid0, 0);
        chk("abort_rdata0", rdata0, 0);
        chk("abort_gnt0", gnt0, 1);
        chk("abort_gnt1", gnt1, 0);

        // Idle with junk on the non-requesting inputs: bus stays quiet
        for (int i = 0; i < 3; i++) begin
            drv(0, 0,1,0,3'd7,32'h12345678, 0,1,0,3'd6,32'h87654321);
            chk("idle_gnt0", gnt0, 0);
            chk("idle_gnt1", gnt1, 0);
            chk("idle_we", rf_we, 0);
            chk("idle_waddr", rf_wAddr, 0);
            chk("idle_wdata", rf_wData, 0);
            chk("idle_raddr", rf_rAddr, 0);
            chk("idle_rdata0", rdata0, 32'hDEADBEEF);
            chk("idle_rvalid0", rvalid0, i == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rf_arbiter
`default_nettype wire
